// File: rtl/spi_rx_uart_tx.sv
// Byte FIFO fed by single-cycle strobes from the SPI receiver, drained onto an
// 8N1 UART line (LSB first). Absorbs whole read bursts far faster than the baud rate.
module spi_rx_uart_tx #(
  parameter int baud_cnt_max = 5207,
  parameter int fifo_depth   = 256,
  parameter int addr_w       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_flag,
  output logic              tx,
  output logic              busy,
  output logic [addr_w:0]   fifo_count,
  output logic              overflow
);

  localparam int baud_w = $clog2(baud_cnt_max + 1);

  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;

  state_t              state, state_d;
  logic [baud_w-1:0]   baud_cnt, baud_d;
  logic [2:0]          bit_idx, bit_d;
  logic [7:0]          shift, shift_d;
  logic                tx_d;
  logic                pop;

  logic [7:0]          mem [fifo_depth];
  logic [addr_w-1:0]   wr_ptr, rd_ptr;
  logic [7:0]          rd_data;
  logic                full, empty, wr_en, baud_end;
  logic [2:0]          bit_nxt;

  assign full     = (fifo_count == (addr_w + 1)'(fifo_depth));
  assign empty    = (fifo_count == '0);
  assign wr_en    = in_flag && !full;
  assign baud_end = (baud_cnt == baud_w'(baud_cnt_max));
  assign bit_nxt  = bit_idx + 3'd1;
  assign busy     = (state != IDLE);

  // NOTE: storage has no reset; pointers and count define what is valid, and a
  // resettable array would prevent mapping onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
      rd_data    <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr  <= rd_ptr + 1'b1;
        rd_data <= mem[rd_ptr];
      end
      case ({wr_en, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      // A pop in the same cycle does not rescue a strobe that met a full FIFO.
      if (in_flag && full) overflow <= 1'b1;
    end
  end

  // tx is computed from the next state so it changes on the same edge as the state/bit.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d = state;
    baud_d  = baud_cnt;
    bit_d   = bit_idx;
    shift_d = shift;
    tx_d    = tx;
    pop     = 1'b0;
    case (state)
      IDLE: begin
        tx_d = 1'b1;
        if (!empty) begin
          pop     = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        shift_d = rd_data;
        baud_d  = '0;
        tx_d    = 1'b0;
        state_d = START;
      end
      START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          tx_d    = shift[0];
          state_d = DATA;
        end else begin
          baud_d = baud_cnt + 1'b1;
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_idx == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            bit_d = bit_nxt;
            tx_d  = shift[bit_nxt];
          end
        end else begin
          baud_d = baud_cnt + 1'b1;
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (baud_end) begin
          baud_d = '0;
          if (!empty) begin
            pop     = 1'b1;
            state_d = LOAD;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_cnt + 1'b1;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed above.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= 3'd0;
      shift    <= '0;
      tx       <= 1'b1;
    end else begin
      state    <= state_d;
      baud_cnt <= baud_d;
      bit_idx  <= bit_d;
      shift    <= shift_d;
      tx       <= tx_d;
    end
  end

endmodule
